// File: rtl/outclk_pkg.sv
`default_nettype none
//==============================================================================
// Module : outclk_pkg
// Types and command-byte field positions shared by out_clk_div_ctrl.
// Rev    : 1.0  initial release
//==============================================================================
package outclk_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_INT  = 2'b01,
    MODE_EXT  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_DIV = 1'b1
  } pstate_e;

  localparam int c_HDR_BIT     = 7;
  localparam int c_CH_MSB      = 6;
  localparam int c_CH_LSB      = 4;
  localparam int c_MODE_MSB    = 3;
  localparam int c_MODE_LSB    = 2;
  localparam int c_GLB_REALIGN = 0;
  localparam int c_GLB_CLRERR  = 1;

`ifdef OUTCLK_STATUS_EN
  localparam logic [1:0] c_QUERY_CODE = 2'b11;
`endif

endpackage
`default_nettype wire

// File: rtl/outclk_chan.sv
`default_nettype none
//==============================================================================
// Module : outclk_chan
// One divided-clock channel: counter, pending config, apply logic, outputs.
// Rev    : 1.0  initial release
//==============================================================================
module outclk_chan
  import outclk_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ext_tick,
  input  logic             i_wr,
  input  mode_e            i_wmode,
  input  logic [DIV_W-1:0] i_wdiv,
  input  logic             i_realign,
  output logic             o_clk,
  output logic             o_ce,
`ifdef OUTCLK_STATUS_EN
  output logic [1:0]       o_mode,
`endif
  output logic             o_pend
);

  mode_e            r_mode;
  mode_e            r_pmode;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pdiv;
  logic [DIV_W-1:0] r_cnt;
  logic             r_clk;
  logic             r_ce;
  logic             r_pend;

  logic w_tick;
  logic w_wrap;
  logic w_now;
  logic w_apply;

  assign w_tick  = (r_mode == MODE_INT) || ((r_mode == MODE_EXT) && i_ext_tick);
  assign w_wrap  = w_tick && (r_cnt == r_div);
  assign w_now   = (r_mode == MODE_OFF) || (r_mode == MODE_HOLD) || (r_pmode == MODE_OFF);
  // A running channel only switches on its falling wrap, so no runt high phase.
  assign w_apply = r_pend && (w_now || (w_wrap && r_clk));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode  <= MODE_OFF;
      r_pmode <= MODE_OFF;
      r_div   <= '0;
      r_pdiv  <= '0;
      r_cnt   <= '0;
      r_clk   <= 1'b0;
      r_ce    <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_ce <= 1'b0;
      if (i_wr) begin
        r_pend  <= 1'b1;
        r_pmode <= i_wmode;
        r_pdiv  <= i_wdiv;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end

      if (w_apply) begin
        r_mode <= r_pmode;
        r_div  <= r_pdiv;
        if (!((r_mode == MODE_HOLD) && (r_pmode == MODE_HOLD))) begin
          r_cnt <= '0;
          r_clk <= 1'b0;
        end
      end else begin
        case (r_mode)
          MODE_OFF: begin
            r_cnt <= '0;
            r_clk <= 1'b0;
          end
          MODE_INT, MODE_EXT: begin
            if (w_wrap) begin
              r_cnt <= '0;
              r_clk <= ~r_clk;
              r_ce  <= ~r_clk;
            end else if (w_tick) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          MODE_HOLD: ;
          default: ;
        endcase
      end

      if (i_realign) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        r_ce  <= 1'b0;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_ce   = r_ce;
  assign o_pend = r_pend;
`ifdef OUTCLK_STATUS_EN
  assign o_mode = r_mode;
`endif

endmodule
`default_nettype wire

// File: rtl/out_clk_div_ctrl.sv
`default_nettype none
//==============================================================================
// Module : out_clk_div_ctrl
// N_CH divided clocks/enables with a byte-wide command parser.
// Optional status query output enabled by macro OUTCLK_STATUS_EN.
// Rev    : 1.0  initial release
//==============================================================================
module out_clk_div_ctrl
  import outclk_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int DIV_W = 8
) (
  input  logic            CLKin,
  input  logic            RSTn,
  input  logic [7:0]      cmd,
  input  logic            wcmd,
  input  logic            ext_tick,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] ce_out,
  output logic [N_CH-1:0] pend,
`ifdef OUTCLK_STATUS_EN
  output logic [7:0]      stat,
`endif
  output logic            err
);

  localparam logic [3:0] c_NCH = 4'(N_CH);

  pstate_e    r_state;
  logic [2:0] r_ch;
  mode_e      r_hmode;
  logic       r_err;

  logic w_is_hdr;
  logic w_div_wr;
  logic w_realign;
  logic w_ch_bad;

  assign w_is_hdr  = cmd[c_HDR_BIT];
  assign w_div_wr  = wcmd && (r_state == ST_WAIT_DIV);
  assign w_realign = wcmd && (r_state == ST_IDLE) && !w_is_hdr && cmd[c_GLB_REALIGN];
  assign w_ch_bad  = {1'b0, r_ch} >= c_NCH;

`ifdef OUTCLK_STATUS_EN
  logic [1:0] w_mode [N_CH];
  logic [7:0] w_stat_nxt;
  logic [7:0] r_stat;
  logic       w_query;
  logic       w_q_bad;

  assign w_query = cmd[1:0] == c_QUERY_CODE;
  assign w_q_bad = {1'b0, cmd[c_CH_MSB:c_CH_LSB]} >= c_NCH;

  // Out-of-range channels match no index and read back as zero.
  always_comb begin
    w_stat_nxt = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      if (cmd[c_CH_MSB:c_CH_LSB] == 3'(i)) begin
        w_stat_nxt = {pend[i], w_mode[i], clk_out[i], 4'h0};
      end
    end
  end

  assign stat = r_stat;
`endif

  always_ff @(posedge CLKin or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_hmode <= MODE_OFF;
      r_err   <= 1'b0;
`ifdef OUTCLK_STATUS_EN
      r_stat  <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wcmd) begin
            if (w_is_hdr) begin
`ifdef OUTCLK_STATUS_EN
              if (w_query) begin
                r_stat <= w_stat_nxt;
                if (w_q_bad) r_err <= 1'b1;
              end else begin
                r_ch    <= cmd[c_CH_MSB:c_CH_LSB];
                r_hmode <= mode_e'(cmd[c_MODE_MSB:c_MODE_LSB]);
                r_state <= ST_WAIT_DIV;
              end
`else
              r_ch    <= cmd[c_CH_MSB:c_CH_LSB];
              r_hmode <= mode_e'(cmd[c_MODE_MSB:c_MODE_LSB]);
              r_state <= ST_WAIT_DIV;
`endif
            end else if (cmd[c_GLB_CLRERR]) begin
              r_err <= 1'b0;
            end
          end
        end
        ST_WAIT_DIV: begin
          // Any byte here is the divisor, even one with the header bit set.
          if (wcmd) begin
            if (w_ch_bad) r_err <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    outclk_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .i_clk      (CLKin),
      .i_rst_n    (RSTn),
      .i_ext_tick (ext_tick),
      .i_wr       (w_div_wr && (r_ch == 3'(g))),
      .i_wmode    (r_hmode),
      .i_wdiv     (cmd[DIV_W-1:0]),
      .i_realign  (w_realign),
      .o_clk      (clk_out[g]),
      .o_ce       (ce_out[g]),
`ifdef OUTCLK_STATUS_EN
      .o_mode     (w_mode[g]),
`endif
      .o_pend     (pend[g])
    );
  end

  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_out_clk_div_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_out_clk_div_ctrl
// Directed self-checking bench for out_clk_div_ctrl (N_CH=3, DIV_W=8).
// Rev    : 1.0  initial release
//==============================================================================
module tb_out_clk_div_ctrl;

  logic       CLKin = 1'b0;
  logic       RSTn;
  logic [7:0] cmd;
  logic       wcmd;
  logic       ext_tick;
  logic [2:0] clk_out;
  logic [2:0] ce_out;
  logic [2:0] pend;
  logic       err;
`ifdef OUTCLK_STATUS_EN
  logic [7:0] stat;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [11:0] v_clk, v_ce;
  logic [9:0]  v_pend, v_frz;
  logic [6:0]  v_a, v_ace, v_b;
  logic        v_bce;
  logic [5:0]  v_c0, v_k0, v_c2, v_k2;
  logic [3:0]  v_off;
  logic [2:0]  v_acc;

  always #5 CLKin = ~CLKin;

  out_clk_div_ctrl #(
    .N_CH (3),
    .DIV_W(8)
  ) dut (
    .CLKin   (CLKin),
    .RSTn    (RSTn),
    .cmd     (cmd),
    .wcmd    (wcmd),
    .ext_tick(ext_tick),
    .clk_out (clk_out),
    .ce_out  (ce_out),
    .pend    (pend),
`ifdef OUTCLK_STATUS_EN
    .stat    (stat),
`endif
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    cmd  = b;
    wcmd = 1'b1;
    @(negedge CLKin);
    wcmd = 1'b0;
    cmd  = 8'h00;
  endtask

  initial begin
    RSTn = 1'b0; wcmd = 1'b0; cmd = 8'h00; ext_tick = 1'b0;
    repeat (2) @(negedge CLKin);
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_ce", 32'(ce_out), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    RSTn = 1'b1;
    @(negedge CLKin);

    // ch0 INT D=2: period 6, 3 high / 3 low
    send(8'h84); send(8'h02);
    chk("t1_pend_set", 32'(pend), 32'h1);
    @(negedge CLKin);
    chk("t1_pend_clr", 32'(pend), 32'h0);
    chk("t1_clk_start", 32'(clk_out), 32'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLKin);
      v_clk[k] = clk_out[0];
      v_ce[k]  = ce_out[0];
    end
    chk("t1_clk_wave", 32'(v_clk), 32'h71C);
    chk("t1_ce_wave", 32'(v_ce), 32'h104);

    // mid-period change to D=0 waits for the falling wrap
    send(8'h84); send(8'h00);
    chk("t2_pend_set", 32'(pend), 32'h1);
    for (int j = 0; j < 10; j++) begin
      @(negedge CLKin);
      v_clk[j]  = clk_out[0];
      v_ce[j]   = ce_out[0];
      v_pend[j] = pend[0];
    end
    chk("t2_clk_wave", 32'(v_clk[9:0]), 32'h157);
    chk("t2_ce_wave", 32'(v_ce[9:0]), 32'h151);
    chk("t2_pend_wave", 32'(v_pend), 32'h007);

    // switch ch0 OFF: applies immediately
    send(8'h80); send(8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLKin);
      v_off[k] = clk_out[0] | ce_out[0];
    end
    chk("t2_off", 32'(v_off), 32'h0);

    // ch1 EXT D=1 with ext_tick every 5 cycles
    send(8'h98); send(8'h01);
    repeat (2) @(negedge CLKin);
    v_bce = 1'b0;
    for (int n = 0; n < 7; n++) begin
      ext_tick = 1'b1;
      @(negedge CLKin);
      ext_tick = 1'b0;
      v_a[n]   = clk_out[1];
      v_ace[n] = ce_out[1];
      repeat (4) begin
        @(negedge CLKin);
        v_bce = v_bce | ce_out[1];
      end
      v_b[n] = clk_out[1];
    end
    chk("t3_clk_at_tick", 32'(v_a), 32'h66);
    chk("t3_ce_at_tick", 32'(v_ace), 32'h22);
    chk("t3_clk_between", 32'(v_b), 32'h66);
    chk("t3_ce_between", 32'(v_bce), 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLKin);
      v_frz[k] = clk_out[1];
    end
    chk("t3_frozen", 32'(v_frz), 32'h3FF);

    // ch0 INT D=3, ch2 INT D=1, then global realign
    send(8'h84); send(8'h03);
    send(8'hA4); send(8'h01);
    repeat (5) @(negedge CLKin);
    send(8'h01);
    chk("t4_realign_clk", 32'(clk_out), 32'h0);
    chk("t4_realign_ce", 32'(ce_out), 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge CLKin);
      v_c0[k] = ce_out[0];
      v_k0[k] = clk_out[0];
      v_c2[k] = ce_out[2];
      v_k2[k] = clk_out[2];
    end
    chk("t4_ce0", 32'(v_c0), 32'h08);
    chk("t4_clk0", 32'(v_k0), 32'h38);
    chk("t4_ce2", 32'(v_c2), 32'h22);
    chk("t4_clk2", 32'(v_k2), 32'h26);

    // out-of-range channel header sets err; global clear
    send(8'hF4); send(8'h05);
    chk("t5_err_set", 32'(err), 32'h1);
    chk("t5_no_pend", 32'(pend), 32'h0);
    send(8'h02);
    chk("t5_err_clr", 32'(err), 32'h0);

    // reset in WAIT_DIV with pend[1] set and err set
    send(8'hF4); send(8'h05);
    chk("t6_err_set", 32'(err), 32'h1);
    send(8'h94); send(8'h02);
    chk("t6_pend1", 32'(pend), 32'h2);
    send(8'h94); send(8'h05);
    chk("t6_pend1_overwrite", 32'(pend), 32'h2);
    send(8'h84);
    #2 RSTn = 1'b0;
    #1;
    chk("t6_rst_clk", 32'(clk_out), 32'h0);
    chk("t6_rst_ce", 32'(ce_out), 32'h0);
    chk("t6_rst_pend", 32'(pend), 32'h0);
    chk("t6_rst_err", 32'(err), 32'h0);
    @(negedge CLKin);
    RSTn = 1'b1;
    send(8'h03);
    chk("t6_global_not_div", 32'(pend), 32'h0);
    chk("t6_err_after", 32'(err), 32'h0);
    v_acc = 3'b000;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLKin);
      v_acc = v_acc | clk_out | pend;
    end
    chk("t6_idle_after", 32'(v_acc), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
